iq_freelist_writer: RTL



---
 rtl/iq_free_pkg.sv | 16 +
 rtl/iq_freelist_writer_if.sv | 26 ++
 rtl/iq_free_select.sv | 41 ++++
 rtl/iq_freelist_writer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/iq_free_pkg.sv
// Shared types and default sizing for the issue-queue free-list writer.
package iq_free_pkg;

  localparam int unsigned IQ_DEPTH      = 32;
  localparam int unsigned IQ_INDEX      = 5;
  localparam int unsigned IQ_FREE_W     = 4;
  localparam int unsigned IQ_DISP_W     = 4;
  localparam int unsigned IQ_FREE_CNT_W = IQ_INDEX + 1;

  typedef enum logic {INIT, RUN} iq_free_state_t;

  typedef logic [IQ_INDEX-1:0]               iq_free_idx_t;
  typedef iq_free_idx_t [IQ_FREE_W-1:0]      iq_free_addr_t;
  typedef iq_free_idx_t [IQ_FREE_W-1:0]      iq_free_data_t;

endpackage

// File: rtl/iq_freelist_writer_if.sv
// Free/alloc inputs and free-list RAM write-port bundle of the IQ free-list writer.
interface iq_freelist_writer_if #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned INDEX  = 5,
  parameter int unsigned FREE_W = 4,
  parameter int unsigned DISP_W = 4
);
  logic [DEPTH-1:0]              freedVector_i;
  logic [$clog2(DISP_W):0]       allocCnt_i;
  logic [FREE_W-1:0]             we_o;
  logic [FREE_W-1:0][INDEX-1:0]  addrWr_o;
  logic [FREE_W-1:0][INDEX-1:0]  dataWr_o;
  logic [INDEX:0]                freeCnt_o;
  logic [INDEX-1:0]              tailPtr_o;
  logic                          ready_o;

  modport master (
    input  freedVector_i, allocCnt_i,
    output we_o, addrWr_o, dataWr_o, freeCnt_o, tailPtr_o, ready_o
  );

  modport slave (
    output freedVector_i, allocCnt_i,
    input  we_o, addrWr_o, dataWr_o, freeCnt_o, tailPtr_o, ready_o
  );
endinterface

// File: rtl/iq_free_select.sv
// Combinational picker of the lowest PORTS set bits of req; k-th lowest goes to port k.
module iq_free_select #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned PORTS = 4,
  parameter int unsigned IDX_W = 5,
  parameter int unsigned CNT_W = $clog2(PORTS + 1)
) (
  input  logic [WIDTH-1:0]            req,
  output logic [PORTS-1:0]            valid,
  output logic [PORTS-1:0][IDX_W-1:0] idx,
  output logic [WIDTH-1:0]            grant,
  output logic [CNT_W-1:0]            count
);

  logic [WIDTH-1:0] rem;
  logic             found;

  // Each port takes the lowest bit still left after earlier ports removed theirs.
  always_comb begin
    valid = '0;
    idx   = '0;
    grant = '0;
    count = '0;
    rem   = req;
    found = 1'b0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      found = 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (!found && rem[i]) begin
          found    = 1'b1;
          valid[k] = 1'b1;
          idx[k]   = IDX_W'(i);
          grant[i] = 1'b1;
          rem[i]   = 1'b0;
        end
      end
      count = count + CNT_W'(valid[k]);
    end
  end

endmodule

// File: rtl/iq_freelist_writer.sv
// IQ free-list write controller: identity-init of the RAM, then packs freed entries at the tail.
// Define IQ_FREE_BYPASS_EN to let a free be written in the same cycle it arrives.
module iq_freelist_writer
  import iq_free_pkg::*;
#(
  parameter int unsigned DEPTH  = IQ_DEPTH,
  parameter int unsigned INDEX  = IQ_INDEX,
  parameter int unsigned FREE_W = IQ_FREE_W,
  parameter int unsigned DISP_W = IQ_DISP_W
) (
  input logic             clk,
  input logic             reset,
  iq_freelist_writer_if.master bus
);

  localparam int unsigned SEL_W   = $clog2(FREE_W + 1);
  localparam int unsigned ACC_W   = INDEX + 2;
  localparam int unsigned ALLOC_W = $clog2(DISP_W) + 1;

  iq_free_state_t state_q, state_d;
  logic [INDEX-1:0]             init_cnt_q, init_cnt_d;
  logic [INDEX-1:0]             tail_q, tail_d;
  logic [DEPTH-1:0]             pending_q, pending_d;
  logic [INDEX:0]               free_cnt_q, free_cnt_d;
  logic                         ready_q;

  logic [DEPTH-1:0]             sel_req, granted;
  logic [FREE_W-1:0]            sel_valid;
  logic [FREE_W-1:0][INDEX-1:0] sel_idx;
  logic [SEL_W-1:0]             nsel;
  logic [ALLOC_W-1:0]           alloc_cnt;
  logic [ACC_W-1:0]             free_acc;

  logic [FREE_W-1:0]            we;
  logic [FREE_W-1:0][INDEX-1:0] addr, data;

  assign alloc_cnt = bus.allocCnt_i;

`ifdef IQ_FREE_BYPASS_EN
  assign sel_req = pending_q | bus.freedVector_i;
`else
  assign sel_req = pending_q;
`endif

  iq_free_select #(
    .WIDTH (DEPTH),
    .PORTS (FREE_W),
    .IDX_W (INDEX),
    .CNT_W (SEL_W)
  ) u_select (
    .req   (sel_req),
    .valid (sel_valid),
    .idx   (sel_idx),
    .grant (granted),
    .count (nsel)
  );

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    tail_d     = tail_q;
    pending_d  = pending_q;
    free_cnt_d = free_cnt_q;
    free_acc   = '0;
    we         = '0;
    addr       = '0;
    data       = '0;
    case (state_q)
      INIT: begin
        for (int unsigned k = 0; k < FREE_W; k++) begin
          we[k]   = 1'b1;
          addr[k] = init_cnt_q + INDEX'(k);
          data[k] = init_cnt_q + INDEX'(k);
        end
        init_cnt_d = init_cnt_q + INDEX'(FREE_W);
        free_cnt_d = free_cnt_q + (INDEX + 1)'(FREE_W);
        if (ACC_W'(init_cnt_q) + ACC_W'(FREE_W) == ACC_W'(DEPTH))
          state_d = RUN;
      end
      RUN: begin
        for (int unsigned k = 0; k < FREE_W; k++) begin
          if (sel_valid[k]) begin
            we[k]   = 1'b1;
            addr[k] = tail_q + INDEX'(k);
            data[k] = sel_idx[k];
          end
        end
        tail_d     = tail_q + INDEX'(nsel);
        free_acc   = ACC_W'(free_cnt_q) + ACC_W'(nsel) - ACC_W'(alloc_cnt);
        free_cnt_d = free_acc[INDEX:0];
`ifdef IQ_FREE_BYPASS_EN
        pending_d  = (pending_q | bus.freedVector_i) & ~granted;
`else
        // A re-free of an entry granted this cycle must survive, so OR after the clear.
        pending_d  = (pending_q & ~granted) | bus.freedVector_i;
`endif
      end
      default: state_d = INIT;
    endcase
    if (reset) begin
      we   = '0;
      addr = '0;
      data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      tail_q     <= '0;
      pending_q  <= '0;
      free_cnt_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      tail_q     <= tail_d;
      pending_q  <= pending_d;
      free_cnt_q <= free_cnt_d;
      ready_q    <= (state_d == RUN);
    end
  end

  // Dispatch over-allocation and double frees are protocol violations upstream.
  always_ff @(posedge clk) begin
    if (!reset && state_q == RUN) begin
      assert (ACC_W'(alloc_cnt) <= ACC_W'(free_cnt_q));
      assert (ACC_W'(free_cnt_q) + ACC_W'(nsel) <= ACC_W'(DEPTH));
    end
  end

  assign bus.we_o      = we;
  assign bus.addrWr_o  = addr;
  assign bus.dataWr_o  = data;
  assign bus.freeCnt_o = free_cnt_q;
  assign bus.tailPtr_o = tail_q;
  assign bus.ready_o   = ready_q;

endmodule
